pic_mc: RTL and testbench

- Parametrised multi-channel successor to the core's two-source interrupt controller.
- Takes NUM_SRC synchronised interrupt requests. Each channel is level- or edge-triggered, individually enabled, and arbitrated by fixed priority or round-robin.
- At most one interrupt is in progress at a time; it is accepted on an instruction valid in D and retired by ertn in W.
- Sits between the CSR block (enables, pending readback) and the pipeline's D-stage exception logic.

---
 rtl/pic_pkg.sv | 13 +
 rtl/pic_arb.sv | 38 +++
 rtl/pic_mc.sv | 101 ++++++++++
 tb/tb_pic_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants and state encoding for the multi-channel interrupt controller.
package pic_pkg;

   localparam int PIC_PRIO_FIXED = 0;
   localparam int PIC_PRIO_RR    = 1;
   localparam int PIC_MAX_SRC    = 32;

   typedef enum logic {
      PIC_IDLE   = 1'b0,
      PIC_ACTIVE = 1'b1
   } pic_state_e;

endpackage

// File: rtl/pic_arb.sv
// Combinational picker: rotate requests by the start pointer, find the first set bit,
// then rotate the index back. Fixed priority is the same path with the pointer forced to 0.
module pic_arb #(
   parameter int NUM_SRC = 4,
   parameter int IDW     = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [IDW-1:0]     rr_ptr_i,
   input  logic               mode_i,
   output logic [IDW-1:0]     winner_o,
   output logic               any_o
);

   localparam logic [IDW:0] NSRC = (IDW+1)'(NUM_SRC);

   logic [IDW-1:0]         ptr;
   logic [2*NUM_SRC-1:0]   dbl;
   logic [NUM_SRC-1:0]     rot;
   logic [IDW-1:0]         off;
   logic [IDW:0]           sum;

   always_comb begin
      ptr = mode_i ? rr_ptr_i : '0;
      dbl = {req_i, req_i} >> ptr;
      rot = dbl[NUM_SRC-1:0];
      off = '0;
      // Descending scan so the lowest set position is the one that sticks.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (rot[i]) off = IDW'(i);
      end
      sum = {1'b0, off} + {1'b0, ptr};
      if (sum >= NSRC) sum = sum - NSRC;
   end

   assign any_o    = |req_i;
   assign winner_o = any_o ? sum[IDW-1:0] : '0;

endmodule

// File: rtl/pic_mc.sv
// Multi-channel interrupt controller: per-channel level/edge pending, enable masking,
// fixed or round-robin arbitration, one interrupt in progress from D-stage accept to ertn.
module pic_mc
   import pic_pkg::*;
#(
   parameter int                 NUM_SRC   = 4,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
   parameter int                 PRIO_MODE = PIC_PRIO_FIXED,
   parameter int                 IDW       = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_SRC-1:0] intr_src_sync,
   input  logic [NUM_SRC-1:0] intr_en,
   input  logic               vld_d,
   input  logic               ertn_w,
   output logic               intr_sync,
   output logic               intr_sync_pulse,
   output logic [IDW-1:0]     intr_id,
   output logic               intr_inprog,
   output logic [NUM_SRC-1:0] pic_csr_intr_pend
);

   pic_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] prev_q;
   logic [IDW-1:0]     id_q, id_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

   logic [NUM_SRC-1:0] rise, edge_pend, eff_pend, req, win_oh;
   logic [IDW-1:0]     winner;
   logic               any, accept, active;

   assign rise      = intr_src_sync & ~prev_q;
   assign edge_pend = pend_q | rise;

   // Qualified by resetn so every output, including the combinational ones, reads 0 in reset.
   assign eff_pend = resetn ? ((EDGE_MASK & edge_pend) | (~EDGE_MASK & intr_src_sync))
                            : '0;
   assign req      = eff_pend & intr_en;

   pic_arb #(
      .NUM_SRC (NUM_SRC),
      .IDW     (IDW)
   ) u_arb (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .mode_i   (PRIO_MODE == PIC_PRIO_RR),
      .winner_o (winner),
      .any_o    (any)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         PIC_IDLE: begin
            if (vld_d && any) begin
               accept  = 1'b1;
               state_d = PIC_ACTIVE;
            end
         end
         PIC_ACTIVE: begin
            if (ertn_w) state_d = PIC_IDLE;
         end
         default: state_d = PIC_IDLE;
      endcase
   end

   assign active = (state_q == PIC_ACTIVE);
   assign win_oh = accept ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << winner) : '0;

   // Acceptance clear wins over a rise landing in the same cycle.
   assign pend_d   = EDGE_MASK & edge_pend & ~win_oh;
   assign id_d     = accept ? winner : id_q;
   assign rr_ptr_d = !accept                     ? rr_ptr_q :
                     (winner == IDW'(NUM_SRC-1)) ? '0       : winner + IDW'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= PIC_IDLE;
         pend_q   <= '0;
         prev_q   <= '0;
         id_q     <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         prev_q   <= intr_src_sync;
         id_q     <= id_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign intr_sync         = accept | active;
   assign intr_sync_pulse   = accept;
   assign intr_id           = accept ? winner : (active ? id_q : '0);
   assign intr_inprog       = active;
   assign pic_csr_intr_pend = eff_pend;

endmodule

// File: tb/tb_pic_mc.sv
// Directed bench: three pic_mc instances (fixed/level, round-robin/level, fixed/mixed edge).
module tb_pic_mc;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic [3:0] fx_src, fx_en, fx_pend;
   logic       fx_vld, fx_ertn, fx_sync, fx_pulse, fx_inprog;
   logic [1:0] fx_id;

   logic [3:0] rr_src, rr_en, rr_pend;
   logic       rr_vld, rr_ertn, rr_sync, rr_pulse, rr_inprog;
   logic [1:0] rr_id;

   logic [3:0] ed_src, ed_en, ed_pend;
   logic       ed_vld, ed_ertn, ed_sync, ed_pulse, ed_inprog;
   logic [1:0] ed_id;

   int checks = 0;
   int fails  = 0;

   pic_mc #(.NUM_SRC(4), .EDGE_MASK(4'b0000), .PRIO_MODE(0)) u_fx (
      .clk(clk), .resetn(resetn), .intr_src_sync(fx_src), .intr_en(fx_en),
      .vld_d(fx_vld), .ertn_w(fx_ertn), .intr_sync(fx_sync), .intr_sync_pulse(fx_pulse),
      .intr_id(fx_id), .intr_inprog(fx_inprog), .pic_csr_intr_pend(fx_pend));

   pic_mc #(.NUM_SRC(4), .EDGE_MASK(4'b0000), .PRIO_MODE(1)) u_rr (
      .clk(clk), .resetn(resetn), .intr_src_sync(rr_src), .intr_en(rr_en),
      .vld_d(rr_vld), .ertn_w(rr_ertn), .intr_sync(rr_sync), .intr_sync_pulse(rr_pulse),
      .intr_id(rr_id), .intr_inprog(rr_inprog), .pic_csr_intr_pend(rr_pend));

   pic_mc #(.NUM_SRC(4), .EDGE_MASK(4'b1100), .PRIO_MODE(0)) u_ed (
      .clk(clk), .resetn(resetn), .intr_src_sync(ed_src), .intr_en(ed_en),
      .vld_d(ed_vld), .ertn_w(ed_ertn), .intr_sync(ed_sync), .intr_sync_pulse(ed_pulse),
      .intr_id(ed_id), .intr_inprog(ed_inprog), .pic_csr_intr_pend(ed_pend));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {sync, pulse, id, inprog} packed for compact checks
   function automatic logic [31:0] fx_o(); return 32'({fx_sync, fx_pulse, fx_id, fx_inprog}); endfunction
   function automatic logic [31:0] rr_o(); return 32'({rr_sync, rr_pulse, rr_id, rr_inprog}); endfunction
   function automatic logic [31:0] ed_o(); return 32'({ed_sync, ed_pulse, ed_id, ed_inprog}); endfunction

   initial begin
      // 1. reset with every input high
      resetn = 1'b0;
      {fx_src, fx_en, fx_vld, fx_ertn} = '1;
      {rr_src, rr_en, rr_vld, rr_ertn} = '1;
      {ed_src, ed_en, ed_vld, ed_ertn} = '1;
      tick(); tick();
      chk("rst_fx_out",  fx_o(), 32'h0);
      chk("rst_fx_pend", 32'(fx_pend), 32'h0);
      chk("rst_rr_out",  rr_o(), 32'h0);
      chk("rst_ed_out",  ed_o(), 32'h0);
      chk("rst_ed_pend", 32'(ed_pend), 32'h0);
      {fx_src, fx_en, fx_vld, fx_ertn} = '0;
      {rr_src, rr_en, rr_vld, rr_ertn} = '0;
      {ed_src, ed_en, ed_vld, ed_ertn} = '0;
      tick();
      resetn = 1'b1;
      tick();
      fx_src = 4'b1010; fx_vld = 1'b1; #1;
      chk("masked_sync", 32'(fx_sync), 32'h0);
      chk("masked_pend_a", 32'(fx_pend), 32'hA);
      fx_src = 4'b0101; #1;
      chk("masked_pend_b", 32'(fx_pend), 32'h5);
      tick();

      // 2. fixed priority, level
      fx_src = 4'b1010; fx_en = 4'hF; fx_vld = 1'b1; #1;
      chk("fx_accept", fx_o(), 32'b1_1_01_0);
      tick();
      chk("fx_active", fx_o(), 32'b1_0_01_1);
      fx_vld = 1'b0; fx_ertn = 1'b1; #1;
      chk("fx_ertn_cyc", fx_o(), 32'b1_0_01_1);
      tick();
      fx_ertn = 1'b0; #1;
      chk("fx_after_ertn", fx_o(), 32'h0);
      tick();
      chk("fx_vld_block", fx_o(), 32'h0);
      // re-accept with ertn high in IDLE: ertn must be ignored
      fx_vld = 1'b1; fx_ertn = 1'b1; #1;
      chk("fx_reaccept", fx_o(), 32'b1_1_01_0);
      tick();
      fx_ertn = 1'b0; fx_vld = 1'b0; #1;
      chk("fx_ertn_idle_ign", fx_o(), 32'b1_0_01_1);
      fx_ertn = 1'b1; tick();
      fx_ertn = 1'b0; fx_src = 4'b1001; fx_vld = 1'b1; #1;
      chk("fx_lowest", fx_o(), 32'b1_1_00_0);
      tick();
      fx_vld = 1'b0; fx_ertn = 1'b1; tick();
      fx_ertn = 1'b0; fx_src = 4'b0000;

      // 3. round-robin, all four held
      rr_src = 4'hF; rr_en = 4'hF;
      for (int k = 0; k < 5; k++) begin
         rr_vld = 1'b1; #1;
         chk($sformatf("rr_seq%0d", k), rr_o(), 32'({1'b1, 1'b1, 2'(k % 4), 1'b0}));
         tick();
         rr_vld = 1'b0; rr_ertn = 1'b1; tick();
         rr_ertn = 1'b0;
      end
      // pointer is now 1: 4'b1001 -> 3, then wraps -> 0
      rr_src = 4'b1001; rr_vld = 1'b1; #1;
      chk("rr_skip", rr_o(), 32'b1_1_11_0);
      tick();
      rr_vld = 1'b0; rr_ertn = 1'b1; tick();
      rr_ertn = 1'b0; rr_vld = 1'b1; #1;
      chk("rr_wrap", rr_o(), 32'b1_1_00_0);
      tick();
      rr_vld = 1'b0; rr_ertn = 1'b1; tick();
      rr_ertn = 1'b0; rr_src = 4'h0;

      // 4. edge latch on channel 2
      ed_en = 4'hF; ed_vld = 1'b0; ed_src = 4'b0100; #1;
      chk("ed_rise_pend", 32'(ed_pend), 32'h4);
      tick();
      ed_src = 4'b0000; #1;
      chk("ed_latched", 32'(ed_pend), 32'h4);
      chk("ed_no_vld", 32'(ed_sync), 32'h0);
      tick(); tick();
      ed_vld = 1'b1; #1;
      chk("ed_accept", ed_o(), 32'b1_1_10_0);
      tick();
      ed_vld = 1'b0; #1;
      chk("ed_cleared", 32'(ed_pend), 32'h0);
      chk("ed_active", ed_o(), 32'b1_0_10_1);
      ed_ertn = 1'b1; tick();
      ed_ertn = 1'b0; ed_vld = 1'b1; #1;
      chk("ed_no_reaccept", ed_o(), 32'h0);
      tick();
      // rise and accept in the same cycle leaves nothing latched
      ed_src = 4'b0100; #1;
      chk("ed_same_cyc", ed_o(), 32'b1_1_10_0);
      tick();
      ed_vld = 1'b0; #1;
      chk("ed_same_clr", 32'(ed_pend), 32'h0);
      ed_ertn = 1'b1; tick();
      ed_ertn = 1'b0; ed_src = 4'b0000; #1;
      chk("ed_same_idle", ed_o(), 32'h0);
      tick();

      // 5. edge on channel 3 while busy with level channel 0
      ed_src = 4'b0001; ed_vld = 1'b1; #1;
      chk("busy_acc0", ed_o(), 32'b1_1_00_0);
      tick();
      ed_src = 4'b1001; #1;
      chk("busy_no_pulse", ed_o(), 32'b1_0_00_1);
      tick();
      ed_src = 4'b0001; #1;
      chk("busy_pend", 32'(ed_pend), 32'h9);
      ed_src = 4'b0000; ed_ertn = 1'b1; #1;
      chk("busy_pend_edge", 32'(ed_pend), 32'h8);
      chk("busy_ertn_cyc", ed_o(), 32'b1_0_00_1);
      tick();
      ed_ertn = 1'b0; #1;
      chk("busy_acc3", ed_o(), 32'b1_1_11_0);
      tick();
      ed_vld = 1'b0; ed_ertn = 1'b1; tick();
      ed_ertn = 1'b0;

      // 6. reset while ACTIVE with an edge pending
      ed_src = 4'b0100; ed_vld = 1'b1; #1;
      chk("mid_acc2", ed_o(), 32'b1_1_10_0);
      tick();
      ed_src = 4'b1000; ed_vld = 1'b0; tick();
      ed_src = 4'b0000; #1;
      chk("mid_pend", 32'(ed_pend), 32'h8);
      chk("mid_inprog", 32'(ed_inprog), 32'h1);
      resetn = 1'b0; #1;
      chk("mid_rst_out", ed_o(), 32'h0);
      chk("mid_rst_pend", 32'(ed_pend), 32'h0);
      tick();
      resetn = 1'b1; ed_vld = 1'b1; #1;
      chk("mid_post_out", ed_o(), 32'h0);
      chk("mid_post_pend", 32'(ed_pend), 32'h0);
      tick();
      chk("mid_post_out2", ed_o(), 32'h0);
      ed_src = 4'b1000; #1;
      chk("mid_new_edge", ed_o(), 32'b1_1_11_0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
